// File: rtl/lcd_cmd_seq.sv
// -----------------------------------------------------------------------------
// lcd_cmd_seq
//   Upstream command sequencer for the LCD image controller. Host commands are
//   buffered in a FIFO and handed to the controller one at a time, one per
//   busy-low window of the controller. Once the write command (code 0) has been
//   issued the sequencer stops issuing and waits for the controller's done
//   pulse, after which it parks in a terminal state until reset.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous reset, active-low
//   in_cmd     in   4      host command code
//   in_valid   in   1      host push request
//   in_ready   out  1      FIFO accepts a push (not full, not finished)
//   busy       in   1      controller busy flag
//   done       in   1      controller finished writing IRAM
//   cmd        out  4      command to the controller (held between strobes)
//   cmd_valid  out  1      one-cycle command strobe
//   fifo_level out  AW+1   entries held in the FIFO
//   issued_cnt out  CW     commands issued since reset, saturating
//   seq_done   out  1      sticky, set once done is seen after the write cmd
// -----------------------------------------------------------------------------
module lcd_cmd_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    in_cmd,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          busy,
    input  logic          done,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    output logic [AW:0]   fifo_level,
    output logic [CW-1:0] issued_cnt,
    output logic          seq_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DRAIN   = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [AW:0]   LP_LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LP_LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] LP_PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LP_CNT_MAX  = {CW{1'b1}};

    state_t          r_state;
    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [3:0]      r_cmd;
    logic            r_cmd_valid;
    logic [CW-1:0]   r_issued_cnt;
    logic            r_seq_done;

    logic [3:0]      w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_in_ready;
    logic            w_push;
    logic            w_pop_drop;
    logic            w_pop_issue;
    logic            w_pop;

    // Codes 0xC..0xF are not understood by the controller.
    function automatic logic is_illegal(input logic [3:0] code);
        return (code >= 4'hC);
    endfunction

    // FIFO status, push/pop qualification and issue decision.
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_empty     = (r_level == LP_LVL_ZERO);
        w_full      = (r_level == LP_LVL_FULL);
        // Depends on the registered level only, so a pop in the same cycle
        // does not reopen the FIFO until the following cycle.
        w_in_ready  = !w_full && (r_state != S_FIN);
        w_push      = in_valid && w_in_ready;
        w_pop_drop  = 1'b0;
        w_pop_issue = 1'b0;
        if ((r_state == S_IDLE) && !w_empty) begin
            if (is_illegal(w_head)) begin
                w_pop_drop = 1'b1;
            end else if (!busy) begin
                // The head leaves on the edge that enters ISSUE; cmd is
                // captured from it on that same edge.
                w_pop_issue = 1'b1;
            end else begin
                w_pop_issue = 1'b0;
            end
        end else begin
            w_pop_drop  = 1'b0;
            w_pop_issue = 1'b0;
        end
        w_pop = w_pop_drop || w_pop_issue;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= LP_LVL_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 4'h0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_cmd;
                r_wr_ptr        <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LP_LVL_ONE;
                2'b01:   r_level <= r_level - LP_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sequencer FSM with registered command outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cmd        <= 4'h0;
            r_cmd_valid  <= 1'b0;
            r_issued_cnt <= {CW{1'b0}};
            r_seq_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_valid <= 1'b0;
                    if (w_pop_issue) begin
                        r_cmd       <= w_head;
                        r_cmd_valid <= 1'b1;
                        if (r_issued_cnt != LP_CNT_MAX) begin
                            r_issued_cnt <= r_issued_cnt + LP_CNT_ONE;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= (r_cmd == 4'h0) ? S_DRAIN : S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    r_cmd_valid <= 1'b0;
                    if (busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    r_cmd_valid <= 1'b0;
                    if (!busy) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    r_cmd_valid <= 1'b0;
                    if (done) begin
                        r_seq_done <= 1'b1;
                        r_state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_cmd_valid <= 1'b0;
                    r_seq_done  <= 1'b1;
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign fifo_level = r_level;
    assign issued_cnt = r_issued_cnt;
    assign seq_done   = r_seq_done;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_cmd_seq
//   Scoreboard bench for lcd_cmd_seq. Accepted legal commands are queued as the
//   expected strobe sequence (nothing after the first 0 is ever expected); a
//   monitor compares every strobe against the queue head and checks the
//   busy handshake rules. A small controller model raises busy the cycle after
//   each strobe for a random number of cycles.
// -----------------------------------------------------------------------------
module tb_lcd_cmd_seq;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 8;

    logic          clk;
    logic          reset;
    logic [3:0]    in_cmd;
    logic          in_valid;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [AW:0]   fifo_level;
    logic [CW-1:0] issued_cnt;
    logic          seq_done;

    logic busy_hold;
    logic busy_ctrl;
    logic ctrl_en;

    assign busy = busy_hold | busy_ctrl;

    int n_cmp;
    int n_bad;
    int strobes_rst;
    logic [3:0] exp_q[$];
    bit zero_queued;

    bit prev_cv;
    bit first_strobe;
    bit seen_hi;
    bit gap_ok;

    lcd_cmd_seq #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .fifo_level (fifo_level),
        .issued_cnt (issued_cnt),
        .seq_done   (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the n-th following rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One push attempt; the handshake is decided at the edge by in_ready.
    task automatic push(input logic [3:0] c, output bit acc);
        in_cmd   = c;
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        if (acc && !zero_queued) begin
            if (c < 4'hC) exp_q.push_back(c);
            if (c == 4'h0) zero_queued = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while ((strobes_rst < target) && (n < budget)) begin
            cyc(1);
            n++;
        end
        chk("wait_strobes", strobes_rst, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd"}, int'(cmd), 0);
        chk({tag, "_cmd_valid"}, int'(cmd_valid), 0);
        chk({tag, "_fifo_level"}, int'(fifo_level), 0);
        chk({tag, "_issued_cnt"}, int'(issued_cnt), 0);
        chk({tag, "_seq_done"}, int'(seq_done), 0);
    endtask

    // Asynchronous reset in mid-cycle; model state is discarded with the FIFO.
    task automatic do_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        zero_queued = 1'b0;
        in_valid    = 1'b0;
        done        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    // Controller model: busy rises the cycle after a strobe and stays 1..4 cycles.
    initial begin
        int unsigned hold_n;
        busy_ctrl = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid && ctrl_en && reset) begin
                @(posedge clk);
                #1;
                busy_ctrl = 1'b1;
                hold_n = $urandom_range(1, 4);
                repeat (hold_n) @(posedge clk);
                #1;
                busy_ctrl = 1'b0;
            end
        end
    end

    // Monitor: compares each strobe with the scoreboard and checks handshake rules.
    initial begin
        logic [3:0] e;
        prev_cv      = 1'b0;
        first_strobe = 1'b1;
        seen_hi      = 1'b0;
        gap_ok       = 1'b0;
        strobes_rst  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_cv      = 1'b0;
                first_strobe = 1'b1;
                seen_hi      = 1'b0;
                gap_ok       = 1'b0;
                strobes_rst  = 0;
            end else begin
                if (cmd_valid) begin
                    chk("strobe_while_busy", int'(busy), 0);
                    chk("strobe_back_to_back", int'(prev_cv), 0);
                    if (!first_strobe) chk("strobe_busy_gap", int'(gap_ok), 1);
                    if (exp_q.size() == 0) begin
                        chk("strobe_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_cmd", int'(cmd), int'(e));
                    end
                    strobes_rst++;
                    first_strobe = 1'b0;
                    seen_hi      = 1'b0;
                    gap_ok       = 1'b0;
                end else if (busy) begin
                    seen_hi = 1'b1;
                end else if (seen_hi) begin
                    gap_ok = 1'b1;
                end
                prev_cv = cmd_valid;
            end
        end
    end

    initial begin
        bit acc;
        int base;
        int n;
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        in_cmd      = 4'h0;
        in_valid    = 1'b0;
        done        = 1'b0;
        busy_hold   = 1'b0;
        ctrl_en     = 1'b1;
        zero_queued = 1'b0;

        // Reset values while held in reset.
        #2;
        check_reset_outputs("rst");
        busy_hold = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // T1: busy high for 70 cycles, queue 4,4,0, then release.
        push(4'h4, acc); chk("t1_acc0", int'(acc), 1);
        push(4'h4, acc); chk("t1_acc1", int'(acc), 1);
        push(4'h0, acc); chk("t1_acc2", int'(acc), 1);
        cyc(67);
        chk("t1_no_strobe_busy", strobes_rst, 0);
        chk("t1_level", int'(fifo_level), 3);
        busy_hold = 1'b0;
        wait_strobes(3, 300);
        cyc(3);
        chk("t1_issued", int'(issued_cnt), 3);
        chk("t1_drain_ready", int'(in_ready), 1);
        chk("t1_seq_done_early", int'(seq_done), 0);

        // T5: done 20 cycles after the write command, then refused push.
        cyc(20);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        chk("t5_seq_done", int'(seq_done), 1);
        chk("t5_in_ready", int'(in_ready), 0);
        push(4'h3, acc);
        chk("t5_push_refused", int'(acc), 0);
        cyc(30);
        chk("t5_seq_done_sticky", int'(seq_done), 1);
        chk("t5_issued", int'(issued_cnt), 3);
        chk("t5_no_more_strobes", strobes_rst, 3);
        chk("t5_level", int'(fifo_level), 0);

        // T2: fill all 16 entries with busy held, 17th push dropped.
        do_reset("t2_rst");
        busy_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push(4'($urandom_range(1, 11)), acc);
            chk("t2_push_acc", int'(acc), 1);
        end
        chk("t2_level_full", int'(fifo_level), DEPTH);
        chk("t2_ready_full", int'(in_ready), 0);
        push(4'h7, acc);
        chk("t2_17th_dropped", int'(acc), 0);
        chk("t2_level_still_full", int'(fifo_level), DEPTH);
        busy_hold = 1'b0;
        n = 0;
        while (!cmd_valid && (n < 50)) begin
            cyc(1);
            n++;
        end
        chk("t2_first_strobe_seen", int'(cmd_valid), 1);
        chk("t2_ready_after_pop", int'(in_ready), 1);
        chk("t2_level_after_pop", int'(fifo_level), DEPTH - 1);
        wait_strobes(DEPTH, 400);
        cyc(10);
        chk("t2_level_drained", int'(fifo_level), 0);
        chk("t2_issued", int'(issued_cnt), DEPTH);

        // T4: push coinciding with the issue pop leaves the level unchanged.
        base = strobes_rst;
        push(4'h5, acc);
        chk("t4_level_one", int'(fifo_level), 1);
        push(4'h9, acc);
        chk("t4_level_unchanged", int'(fifo_level), 1);
        chk("t4_strobe_now", int'(cmd_valid), 1);
        wait_strobes(base + 2, 100);

        // T3: illegal head is dropped silently, the legal one is issued once.
        cyc(10);
        base = strobes_rst;
        push(4'hD, acc);
        push(4'h5, acc);
        wait_strobes(base + 1, 100);
        cyc(20);
        chk("t3_single_strobe", strobes_rst, base + 1);
        chk("t3_issued", int'(issued_cnt), base + 1);
        chk("t3_level", int'(fifo_level), 0);

        // Random traffic including illegal codes, wrap-around and stray done.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                push(4'($urandom_range(1, 15)), acc);
            end else begin
                done = ($urandom_range(0, 9) == 0);
                cyc(1);
                done = 1'b0;
            end
        end
        n = 0;
        while ((exp_q.size() != 0) && (n < 1000)) begin
            cyc(1);
            n++;
        end
        chk("rand_queue_drained", exp_q.size(), 0);
        cyc(10);
        chk("rand_level", int'(fifo_level), 0);
        chk("rand_issued", int'(issued_cnt), (strobes_rst > 255) ? 255 : strobes_rst);
        chk("rand_stray_done_ignored", int'(seq_done), 0);

        // T6: reset while stuck in WAIT_HI with 5 entries queued.
        ctrl_en = 1'b0;
        cyc(10);
        for (int i = 1; i <= 6; i++) begin
            push(4'(i), acc);
        end
        cyc(5);
        chk("t6_level_before", int'(fifo_level), 5);
        do_reset("t6_rst");
        ctrl_en = 1'b1;
        cyc(20);
        chk("t6_no_strobe", strobes_rst, 0);
        chk("t6_level_after", int'(fifo_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
